x448_scalar_loader: RTL and testbench

Front-end stage for the X448 scalar-multiplication engine. It collects a 448-bit scalar from a 32-bit word stream, applies RFC 7748 clamping, and hands the finished scalar to the scalar-multiplication core over a valid/ready request handshake. Framing errors on the input stream are detected and reported, and the bad frame is discarded. The block sits between the host word bus and the `K`/`req_*` inputs of the scalar-multiplication core.

---
 rtl/x448_scalar_loader.sv | 170 +++++++++++++++++
 tb/tb_x448_scalar_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/x448_scalar_loader.sv
// x448_scalar_loader
// Collects a 448-bit X448 scalar from a little-endian W-bit word stream,
// conditions it for the scalar-multiplication core and presents it over a
// valid/ready request handshake. Malformed frames raise a one-cycle err pulse
// and are discarded.
//
// Build option: define X448_SCALAR_CLAMP_EN to apply RFC 7748 clamping
// (bits 1:0 cleared, bit 447 set). Without it the scalar is loaded raw and
// any frame whose bit 447 is 0 is rejected as an error.
module x448_scalar_loader #(
  parameter int W  = 32,
  parameter int NW = 448 / W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [447:0]   K,
  output logic           req_valid,
  input  logic           req_ready,
  input  logic           req_busy,
  output logic           err
);

  localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NW - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SKIP  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               err_next;
  logic               req_valid_next;
  logic               k_load;

  // Only the upper 448-W bits of the shift register are ever read back: the
  // lowest word is shifted out on the same edge the final word arrives.
  logic [447:W]       sh;
  logic [447:0]       frame_word;
  logic [447:0]       k_value;
  logic               frame_ok;
  logic               accept;
  logic               last_slot;

`ifdef X448_SCALAR_CLAMP_EN
  // RFC 7748 clamp: the core relies on the MSB being set.
  function automatic logic [447:0] clamp(input logic [447:0] x);
    logic [447:0] r;
    r        = x;
    r[1:0]   = 2'b00;
    r[447]   = 1'b1;
    return r;
  endfunction

  assign k_value  = clamp(frame_word);
  assign frame_ok = 1'b1;
`else
  // Raw load: a scalar without its MSB set would violate the core's
  // precondition, so such a frame is refused instead of issued.
  assign k_value  = frame_word;
  assign frame_ok = frame_word[447];
`endif

  // The scalar as it would look after shifting in the current word.
  assign frame_word = {in_data, sh};

  assign in_ready  = !rst && (state == FILL || state == SKIP);
  assign accept    = in_valid && in_ready;
  assign last_slot = (cnt == CNT_LAST);

  // Next-state, counter and pulse decisions for the frame FSM.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    err_next       = 1'b0;
    req_valid_next = 1'b0;
    k_load         = 1'b0;

    case (state)
      FILL: begin
        if (accept) begin
          if (in_last) begin
            cnt_next = '0;
            if (last_slot && frame_ok) begin
              k_load     = 1'b1;
              state_next = ISSUE;
            end else begin
              // Short frame, or a full frame that failed the MSB check.
              err_next = 1'b1;
            end
          end else if (last_slot) begin
            // Too many words: flag once, then drain to the frame end.
            err_next   = 1'b1;
            cnt_next   = '0;
            state_next = SKIP;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end

      SKIP: begin
        if (accept && in_last) begin
          state_next = FILL;
        end
      end

      ISSUE: begin
        if (req_valid && req_ready) begin
          state_next = FILL;
        end else begin
          // Hold off the request while the core is still computing.
          req_valid_next = !req_busy;
        end
      end

      default: begin
        state_next = FILL;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Control registers: word counter, error pulse and request valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      err       <= 1'b0;
      req_valid <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      err       <= err_next;
      req_valid <= req_valid_next;
    end
  end

  // Word shift register; only words of a live frame are shifted in.
  always_ff @(posedge clk) begin
    if (accept && state == FILL) begin
      sh <= frame_word[447:W];
    end
  end

  // Output scalar: holds until the next accepted complete frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      K <= '0;
    end else if (k_load) begin
      K <= k_value;
    end
  end

endmodule

// File: tb/tb_x448_scalar_loader.sv
// Directed testbench for x448_scalar_loader (W = 32, 14 words per scalar).
// Expected scalars follow the same X448_SCALAR_CLAMP_EN setting as the build.
module tb_x448_scalar_loader;

  logic         clk;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [447:0] K;
  logic         req_valid;
  logic         req_ready;
  logic         req_busy;
  logic         err;

  int passed;
  int total;

  x448_scalar_loader #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .K         (K),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_busy  (req_busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [447:0] obs, input logic [447:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // 14-word frame, word i = base | i; returns the raw scalar it forms.
  task automatic send_frame(input logic [31:0] base, output logic [447:0] raw);
    raw = '0;
    for (int i = 0; i < 14; i++) begin
      raw[32*i +: 32] = base | 32'(i);
      send_word(base | 32'(i), (i == 13));
    end
  endtask

  function automatic logic [447:0] model_k(input logic [447:0] raw);
    logic [447:0] r;
    r = raw;
`ifdef X448_SCALAR_CLAMP_EN
    r[1:0] = 2'b00;
    r[447] = 1'b1;
`endif
    return r;
  endfunction

  logic [447:0] raw;
  logic [447:0] k_prev;
  logic [447:0] ones;
  logic [447:0] msb_only;
  int           bad_cycles;

  initial begin
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    req_ready = 1'b1;
    req_busy  = 1'b0;
    ones      = '1;
    msb_only  = '0;
    msb_only[447] = 1'b1;

    // Reset state
    step();
    check("in_ready_in_reset", in_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("reset_K", K, '0);
    check("reset_req_valid", req_valid, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);

    // Clamped load: all-ones scalar
    for (int i = 0; i < 14; i++) send_word(32'hFFFF_FFFF, (i == 13));
    check("ones_in_ready_issue", in_ready, 1'b0);
    check("ones_req_valid_early", req_valid, 1'b0);
    check("ones_err", err, 1'b0);
`ifdef X448_SCALAR_CLAMP_EN
    check("ones_K_lo", K[31:0], 32'hFFFF_FFFC);
`else
    check("ones_K_lo", K[31:0], 32'hFFFF_FFFF);
`endif
    check("ones_K_msb", K[447], 1'b1);
    check("ones_K", K, model_k(ones));
    step();
    check("ones_req_valid_rise", req_valid, 1'b1);
    step();
    check("ones_req_valid_drop", req_valid, 1'b0);
    check("ones_in_ready_back", in_ready, 1'b1);

    // Zero scalar
    k_prev = K;
    for (int i = 0; i < 14; i++) send_word(32'h0, (i == 13));
`ifdef X448_SCALAR_CLAMP_EN
    check("zero_err", err, 1'b0);
    check("zero_K", K, msb_only);
    step();
    check("zero_req_valid", req_valid, 1'b1);
    step();
    check("zero_req_valid_drop", req_valid, 1'b0);
`else
    check("zero_err", err, 1'b1);
    check("zero_K_unchanged", K, k_prev);
    check("zero_in_ready", in_ready, 1'b1);
    step();
    check("zero_err_one_cycle", err, 1'b0);
    check("zero_no_req", req_valid, 1'b0);
    step();
    check("zero_no_req_later", req_valid, 1'b0);
`endif

    // Short frame: in_last on word 5
    k_prev = K;
    for (int i = 0; i < 6; i++) send_word(32'h5555_0000 | 32'(i), (i == 5));
    check("short_err", err, 1'b1);
    check("short_in_ready", in_ready, 1'b1);
    check("short_K_unchanged", K, k_prev);
    step();
    check("short_err_one_cycle", err, 1'b0);
    check("short_no_req", req_valid, 1'b0);
    raw = '0;
    for (int i = 0; i < 14; i++) begin
      raw[32*i +: 32] = 32'h1111_1111 * 32'(i + 1);
      send_word(32'h1111_1111 * 32'(i + 1), (i == 13));
    end
`ifdef X448_SCALAR_CLAMP_EN
    check("after_short_K_lo", K[31:0], 32'h1111_1110);
`else
    check("after_short_K_lo", K[31:0], 32'h1111_1111);
`endif
    check("after_short_K_hi", K[447:416], 32'hEEEE_EEEE);
    check("after_short_K", K, model_k(raw));
    step();
    check("after_short_req", req_valid, 1'b1);
    step();

    // Long frame: 16 words, in_last on word 15
    k_prev = K;
    for (int i = 0; i < 14; i++) send_word(32'h1234_0000 | 32'(i), 1'b0);
    check("long_err", err, 1'b1);
    check("long_in_ready_skip", in_ready, 1'b1);
    send_word(32'h1234_000E, 1'b0);
    check("long_err_one_cycle", err, 1'b0);
    send_word(32'h1234_000F, 1'b1);
    check("long_no_second_err", err, 1'b0);
    check("long_K_unchanged", K, k_prev);
    check("long_no_req", req_valid, 1'b0);
    send_frame(32'hC0DE_0000, raw);
    check("after_long_K_lo", K[31:0], 32'hC0DE_0000);
    check("after_long_K", K, model_k(raw));
    step();
    check("after_long_req", req_valid, 1'b1);
    step();

    // Busy core: request must wait for req_busy to fall
    req_busy = 1'b1;
    send_frame(32'h8765_4300, raw);
    check("busy_K", K, model_k(raw));
    bad_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      if (req_valid !== 1'b0 || in_ready !== 1'b0) bad_cycles++;
      step();
    end
    check("busy_hold_cycles", 32'(bad_cycles), 32'd0);
    req_busy = 1'b0;
    #1;
    check("busy_still_low", req_valid, 1'b0);
    step();
    check("busy_req_rise", req_valid, 1'b1);
    step();
    check("busy_req_drop", req_valid, 1'b0);
    check("busy_in_ready_back", in_ready, 1'b1);

    // Reset at word 7 of a frame
    for (int i = 0; i < 7; i++) send_word(32'hDEAD_0000 | 32'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_0007;
    rst      = 1'b1;
    step();
    in_valid = 1'b0;
    check("rst7_cnt", dut.cnt, '0);
    check("rst7_req_valid", req_valid, 1'b0);
    check("rst7_err", err, 1'b0);
    check("rst7_K", K, '0);
    rst = 1'b0;
    #1;
    send_frame(32'hA5A5_0000, raw);
    check("rst7_fresh_K_lo", K[31:0], 32'hA5A5_0000);
    check("rst7_fresh_K", K, model_k(raw));
    step();
    check("rst7_fresh_req", req_valid, 1'b1);
    step();

    // Reset while a request is pending
    send_frame(32'hBEEF_0000, raw);
    step();
    check("issue_req_pending", req_valid, 1'b1);
    req_ready = 1'b0;
    rst = 1'b1;
    step();
    check("issue_rst_req_drop", req_valid, 1'b0);
    rst = 1'b0;
    req_ready = 1'b1;
    #1;
    check("issue_rst_in_ready", in_ready, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
